// File: rtl/pipeline_control_idt_reader.sv
// Resolves an IRQ number to its two-word IDT entry (flags, handler) through the shared load/store port.
// Hit: 1 cycle; miss: 5 cycles plus busy and response-wait cycles; a response timeout always releases the requester.
module pipeline_control_idt_reader #(
    parameter int P_IRQ_W       = 7,
    parameter int P_ENTRY_SHIFT = 3,
    parameter int P_CACHE_IDX_W = 2,
    parameter int P_TIMEOUT     = 255
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    input  logic [31:0]          iSYSREG_IDTR,
    input  logic                 iIDTR_WRITE,
    input  logic                 iRD_START,
    input  logic [P_IRQ_W-1:0]   iRD_IRQ_NUM,
    output logic                 oRD_BUSY,
    output logic                 oRD_FINISH,
    output logic                 oRD_VALID,
    output logic                 oRD_ERROR,
    output logic [31:0]          oRD_FLAGS,
    output logic [31:0]          oRD_HUNDLER,
    output logic                 oLDST_USE,
    output logic                 oLDST_REQ,
    input  logic                 iLDST_BUSY,
    output logic [1:0]           oLDST_ORDER,
    output logic                 oLDST_RW,
    output logic [31:0]          oLDST_ADDR,
    output logic [31:0]          oLDST_DATA,
    input  logic                 iLDST_REQ,
    input  logic [31:0]          iLDST_DATA
);
    localparam int L_TAG_W   = P_IRQ_W - P_CACHE_IDX_W;
    localparam int L_ENTRIES = 1 << P_CACHE_IDX_W;

    localparam logic [2:0] L_IDLE     = 3'd0;
    localparam logic [2:0] L_REQ_FLG  = 3'd1;
    localparam logic [2:0] L_WAIT_FLG = 3'd2;
    localparam logic [2:0] L_REQ_HDL  = 3'd3;
    localparam logic [2:0] L_WAIT_HDL = 3'd4;
    localparam logic [2:0] L_DONE     = 3'd5;

    logic [2:0]                b_state;
    logic [31:0]               b_base;
    logic [P_CACHE_IDX_W-1:0]  b_idx;
    logic [L_TAG_W-1:0]        b_tag;
    logic                      b_inval;
    logic [15:0]               b_cnt;
    logic                      b_valid;
    logic                      b_error;
    logic [31:0]               b_flags;
    logic [31:0]               b_hundler;

    logic [L_ENTRIES-1:0]      b_c_valid;
    logic [L_TAG_W-1:0]        b_c_tag   [L_ENTRIES];
    logic [31:0]               b_c_flags [L_ENTRIES];
    logic [31:0]               b_c_hdl   [L_ENTRIES];

    logic [P_CACHE_IDX_W-1:0]  start_idx;
    logic [L_TAG_W-1:0]        start_tag;
    logic                      lookup_hit;
    logic                      timeout_hit;
    logic                      fill_en;

    assign start_idx   = iRD_IRQ_NUM[P_CACHE_IDX_W-1:0];
    assign start_tag   = iRD_IRQ_NUM[P_IRQ_W-1:P_CACHE_IDX_W];
    // A same-cycle invalidate beats the lookup so a stale entry is never returned.
    assign lookup_hit  = b_c_valid[start_idx] && !iIDTR_WRITE && (b_c_tag[start_idx] == start_tag);
    assign timeout_hit = (b_cnt == 16'(P_TIMEOUT));
    // Only misses reach WAIT_HDL, so the miss condition is implicit here.
    assign fill_en     = (b_state == L_WAIT_HDL) && iLDST_REQ && b_flags[0]
                         && !b_inval && !iIDTR_WRITE;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            b_state   <= L_IDLE;
            b_base    <= 32'd0;
            b_idx     <= '0;
            b_tag     <= '0;
            b_inval   <= 1'b0;
            b_cnt     <= 16'd0;
            b_valid   <= 1'b0;
            b_error   <= 1'b0;
            b_flags   <= 32'd0;
            b_hundler <= 32'd0;
        end else begin
            case (b_state)
                L_IDLE: begin
                    if (iRD_START) begin
                        b_idx   <= start_idx;
                        b_tag   <= start_tag;
                        b_base  <= iSYSREG_IDTR + (32'(iRD_IRQ_NUM) << P_ENTRY_SHIFT);
                        b_error <= 1'b0;
                        if (lookup_hit) begin
                            b_valid   <= b_c_flags[start_idx][0];
                            b_flags   <= b_c_flags[start_idx];
                            b_hundler <= b_c_hdl[start_idx];
                            b_state   <= L_DONE;
                        end else begin
                            b_valid   <= 1'b0;
                            b_flags   <= 32'd0;
                            b_hundler <= 32'd0;
                            b_state   <= L_REQ_FLG;
                        end
                    end
                end
                L_REQ_FLG, L_REQ_HDL: begin
                    if (!iLDST_BUSY) begin
                        b_cnt   <= 16'd0;
                        b_state <= (b_state == L_REQ_FLG) ? L_WAIT_FLG : L_WAIT_HDL;
                    end
                end
                L_WAIT_FLG, L_WAIT_HDL: begin
                    if (iLDST_REQ) begin
                        if (b_state == L_WAIT_FLG) begin
                            b_flags <= iLDST_DATA;
                            b_state <= L_REQ_HDL;
                        end else begin
                            b_hundler <= iLDST_DATA;
                            b_valid   <= b_flags[0];
                            b_state   <= L_DONE;
                        end
                    end else if (timeout_hit) begin
                        b_error   <= 1'b1;
                        b_valid   <= 1'b0;
                        b_flags   <= 32'd0;
                        b_hundler <= 32'd0;
                        b_state   <= L_DONE;
                    end else begin
                        b_cnt <= b_cnt + 16'd1;
                    end
                end
                L_DONE:  b_state <= L_IDLE;
                default: b_state <= L_IDLE;
            endcase
            // Covers both the start cycle and any cycle of an in-flight fetch.
            if (iIDTR_WRITE) begin
                b_inval <= 1'b1;
            end else if (b_state == L_IDLE && iRD_START) begin
                b_inval <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            b_c_valid <= '0;
        end else if (iIDTR_WRITE) begin
            b_c_valid <= '0;
        end else if (fill_en) begin
            b_c_valid[b_idx] <= 1'b1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (fill_en) begin
            b_c_tag[b_idx]   <= b_tag;
            b_c_flags[b_idx] <= b_flags;
            b_c_hdl[b_idx]   <= iLDST_DATA;
        end
    end

    always_comb begin
        oLDST_ADDR = 32'd0;
        case (b_state)
            L_REQ_FLG, L_WAIT_FLG: oLDST_ADDR = b_base;
            L_REQ_HDL, L_WAIT_HDL: oLDST_ADDR = b_base + 32'd4;
            default:               oLDST_ADDR = 32'd0;
        endcase
    end

    assign oRD_BUSY    = (b_state != L_IDLE);
    assign oRD_FINISH  = (b_state == L_DONE);
    assign oRD_VALID   = b_valid;
    assign oRD_ERROR   = b_error;
    assign oRD_FLAGS   = b_flags;
    assign oRD_HUNDLER = b_hundler;
    assign oLDST_USE   = (b_state == L_REQ_FLG) || (b_state == L_WAIT_FLG)
                      || (b_state == L_REQ_HDL) || (b_state == L_WAIT_HDL);
    assign oLDST_REQ   = (b_state == L_REQ_FLG) || (b_state == L_REQ_HDL);
    assign oLDST_ORDER = 2'h2;
    assign oLDST_RW    = 1'b0;
    assign oLDST_DATA  = 32'd0;

endmodule

// File: tb/tb_pipeline_control_idt_reader.sv
// Directed table of fetches against a small responder, plus reset sequences.
module tb_pipeline_control_idt_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] idtr = 32'd0;
    logic        idtr_wr = 1'b0;
    logic        rd_start = 1'b0;
    logic [6:0]  rd_irq = 7'd0;
    logic        rd_busy, rd_finish, rd_valid, rd_error;
    logic [31:0] rd_flags, rd_hdl;
    logic        ldst_use, ldst_req_o;
    logic        ldst_busy = 1'b0;
    logic [1:0]  ldst_order;
    logic        ldst_rw;
    logic [31:0] ldst_addr, ldst_data_o;
    logic        ldst_req_i = 1'b0;
    logic [31:0] ldst_data_i = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_control_idt_reader #(.P_TIMEOUT(20)) dut (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iSYSREG_IDTR(idtr), .iIDTR_WRITE(idtr_wr),
        .iRD_START(rd_start), .iRD_IRQ_NUM(rd_irq), .oRD_BUSY(rd_busy), .oRD_FINISH(rd_finish),
        .oRD_VALID(rd_valid), .oRD_ERROR(rd_error), .oRD_FLAGS(rd_flags), .oRD_HUNDLER(rd_hdl),
        .oLDST_USE(ldst_use), .oLDST_REQ(ldst_req_o), .iLDST_BUSY(ldst_busy),
        .oLDST_ORDER(ldst_order), .oLDST_RW(ldst_rw), .oLDST_ADDR(ldst_addr),
        .oLDST_DATA(ldst_data_o), .iLDST_REQ(ldst_req_i), .iLDST_DATA(ldst_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] idtr;
        int          wr_cyc;   // -1 none, -2 idle pulse before start, 0 with start, n in cycle n
        logic [6:0]  irq;
        logic [31:0] flg;
        logic [31:0] hdl;
        int          busy;
        int          dly;
        bit          noresp;
        int          lat;
        int          nreq;
        logic [31:0] a0;
        bit          used;
        bit          valid;
        bit          err;
        logic [31:0] eflags;
        logic [31:0] ehdl;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, output int lat, output int nreq,
                           output int addr_bad, output bit used, output int ntaken);
        int rcount = 0;
        int busy_left = v.busy;
        int wcnt = 0;
        lat = -1; nreq = 0; addr_bad = 0; used = 1'b0; ntaken = 0;
        if (v.wr_cyc == -2) begin
            idtr_wr = 1'b1;
            @(negedge clk);
            idtr_wr = 1'b0;
        end
        idtr = v.idtr; rd_irq = v.irq; rd_start = 1'b1;
        idtr_wr = (v.wr_cyc == 0);
        @(negedge clk);
        rd_start = 1'b0;
        for (int c = 1; c < 200; c++) begin
            idtr_wr = (c == v.wr_cyc);
            ldst_req_i = 1'b0;
            ldst_busy = 1'b0;
            if (rd_finish) begin
                lat = c;
                break;
            end
            if (ldst_use) begin
                used = 1'b1;
                if (ldst_addr !== ((rcount == 0) ? v.a0 : v.a0 + 32'd4)) addr_bad++;
            end
            if (ldst_req_o) begin
                nreq++;
                if (rcount == 0 && busy_left > 0) begin
                    ldst_busy = 1'b1;
                    busy_left--;
                end else begin
                    ntaken++;
                    wcnt = 0;
                end
            end else if (ldst_use) begin
                if (!v.noresp && wcnt == v.dly) begin
                    ldst_req_i = 1'b1;
                    ldst_data_i = (rcount == 0) ? v.flg : v.hdl;
                    rcount++;
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
        end
        idtr_wr = 1'b0; ldst_req_i = 1'b0; ldst_busy = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ctl"}, {26'd0, rd_busy, rd_finish, rd_valid, rd_error, ldst_use, ldst_req_o}, 32'd0);
        chk({tag, " addr"}, ldst_addr, 32'd0);
        chk({tag, " flags"}, rd_flags, 32'd0);
        chk({tag, " hdl"}, rd_hdl, 32'd0);
        chk({tag, " const"}, {29'd0, ldst_order, ldst_rw}, {29'd0, 2'h2, 1'b0});
        chk({tag, " data"}, ldst_data_o, 32'd0);
    endtask

    initial begin
        int lat, nreq, abad, ntk;
        bit used;
        vec_t pv;
        vecs = '{
            '{32'h1000, -1,   5, 32'h1,  32'h8000_0040, 0, 0, 1'b0,  5, 2, 32'h1028, 1'b1, 1'b1, 1'b0, 32'h1,  32'h8000_0040},
            '{32'h1000, -1,   5, 32'h3,  32'hdead_0000, 0, 0, 1'b0,  1, 0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h1,  32'h8000_0040},
            '{32'h1000, -1,   9, 32'h11, 32'h9000,      0, 0, 1'b0,  5, 2, 32'h1048, 1'b1, 1'b1, 1'b0, 32'h11, 32'h9000},
            '{32'h1000, -1,   5, 32'h1,  32'h8000_0040, 0, 2, 1'b0,  9, 2, 32'h1028, 1'b1, 1'b1, 1'b0, 32'h1,  32'h8000_0040},
            '{32'h1000, -1,   3, 32'h0,  32'h3333,      0, 0, 1'b0,  5, 2, 32'h1018, 1'b1, 1'b0, 1'b0, 32'h0,  32'h3333},
            '{32'h1000, -1,   3, 32'h0,  32'h4444,      0, 0, 1'b0,  5, 2, 32'h1018, 1'b1, 1'b0, 1'b0, 32'h0,  32'h4444},
            '{32'hFFFF_FF00, -1, 127, 32'h5, 32'h1234,  2, 0, 1'b0,  7, 4, 32'h2F8,  1'b1, 1'b1, 1'b0, 32'h5,  32'h1234},
            '{32'h1000, -1,   6, 32'h1,  32'h7777,      4, 0, 1'b1, 27, 5, 32'h1030, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0},
            '{32'h1000, -1,   6, 32'h1,  32'h6666,      0, 0, 1'b0,  5, 2, 32'h1030, 1'b1, 1'b1, 1'b0, 32'h1,  32'h6666},
            '{32'h1000, -1,   6, 32'h0,  32'h0,         0, 0, 1'b0,  1, 0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h1,  32'h6666},
            '{32'h2000,  0,   5, 32'h1,  32'h5555,      0, 0, 1'b0,  5, 2, 32'h2028, 1'b1, 1'b1, 1'b0, 32'h1,  32'h5555},
            '{32'h2000,  4,  10, 32'h1,  32'hA0A0,      0, 0, 1'b0,  5, 2, 32'h2050, 1'b1, 1'b1, 1'b0, 32'h1,  32'hA0A0},
            '{32'h2000, -1,  10, 32'h1,  32'hA1A1,      0, 0, 1'b0,  5, 2, 32'h2050, 1'b1, 1'b1, 1'b0, 32'h1,  32'hA1A1},
            '{32'h2000, -1,  10, 32'h0,  32'h0,         0, 0, 1'b0,  1, 0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h1,  32'hA1A1},
            '{32'h2000, -2,  10, 32'h1,  32'hA2A2,      0, 0, 1'b0,  5, 2, 32'h2050, 1'b1, 1'b1, 1'b0, 32'h1,  32'hA2A2}
        };

        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], lat, nreq, abad, used, ntk);
            chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d req_cycles", i), nreq, vecs[i].nreq);
            chk($sformatf("v%0d use", i), {31'd0, used}, {31'd0, vecs[i].used});
            chk($sformatf("v%0d taken", i), ntk, !vecs[i].used ? 0 : (vecs[i].noresp ? 1 : 2));
            chk($sformatf("v%0d addr_bad_cycles", i), abad, 0);
            chk($sformatf("v%0d valid/err", i), {30'd0, rd_valid, rd_error}, {30'd0, vecs[i].valid, vecs[i].err});
            chk($sformatf("v%0d flags", i), rd_flags, vecs[i].eflags);
            chk($sformatf("v%0d handler", i), rd_hdl, vecs[i].ehdl);
            @(negedge clk);
            chk($sformatf("v%0d idle_busy", i), {31'd0, rd_busy}, 32'd0);
            chk($sformatf("v%0d hold_handler", i), rd_hdl, vecs[i].ehdl);
        end

        // Reset in WAIT_FLG of a miss
        idtr = 32'h1000; rd_irq = 7'd12; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        @(negedge clk);
        chk("mid wait_flg", {30'd0, ldst_use, ldst_req_o}, {30'd0, 1'b1, 1'b0});
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid reset");
        rst = 1'b0;
        ldst_req_i = 1'b1; ldst_data_i = 32'hFFFF_FFFF;
        @(negedge clk);
        ldst_req_i = 1'b0;
        chk("stray resp busy/finish", {30'd0, rd_busy, rd_finish}, 32'd0);
        chk("stray resp flags", rd_flags, 32'd0);
        @(negedge clk);
        pv = '{32'h2000, -1, 10, 32'h1, 32'hB0B0, 0, 0, 1'b0, 5, 2, 32'h2050, 1'b1, 1'b1, 1'b0, 32'h1, 32'hB0B0};
        run_vec(pv, lat, nreq, abad, used, ntk);
        chk("post-reset latency", lat, 5);
        chk("post-reset use", {31'd0, used}, 32'd1);
        chk("post-reset addr_bad_cycles", abad, 0);
        chk("post-reset handler", rd_hdl, 32'hB0B0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_control_idt_reader.md
# pipeline_control_idt_reader

Parametrised interrupt-descriptor fetch unit in the pipeline control group. On request it resolves an IRQ number to a full two-word IDT entry (flags word, handler address) via the shared load/store port. A small direct-mapped entry cache skips memory on repeat IRQs, and a response timeout guarantees the requester is always released. It replaces the single-word handler reader and adds entry flags, caching, invalidation and error reporting.

## Interface
- P_IRQ_W, 7, IRQ number width
- P_ENTRY_SHIFT, 3, log2 of IDT entry size in bytes (minimum 3)
- P_CACHE_IDX_W, 2, log2 of cache entry count (2^P_CACHE_IDX_W entries; must be < P_IRQ_W)
- P_TIMEOUT, 255, maximum cycles waited for a load response (1..65535)

Ports:
- iCLOCK  in  1  clock
- iRESET_SYNC  in  1  reset; synchronous, active-high
- iSYSREG_IDTR  in  32  IDT base address
- iIDTR_WRITE  in  1  IDTR update strobe; invalidates the whole cache
- iRD_START  in  1  fetch request; accepted only in IDLE
- iRD_IRQ_NUM  in  P_IRQ_W  IRQ to resolve; sampled with iRD_START
- oRD_BUSY  out  1  high in every state except IDLE
- oRD_FINISH  out  1  one-cycle completion pulse
- oRD_VALID  out  1  bit 0 of fetched flags word; 0 on error
- oRD_ERROR  out  1  fetch timed out; valid with oRD_FINISH
- oRD_FLAGS  out  32  fetched flags word
- oRD_HUNDLER  out  32  fetched handler address
- oLDST_USE  out  1  load/store port ownership
- oLDST_REQ  out  1  load request
- iLDST_BUSY  in  1  port busy; request not taken while high
- oLDST_ORDER  out  2  constant 2'h2 (word)
- oLDST_RW  out  1  constant 0 (read)
- oLDST_ADDR  out  32  load address
- oLDST_DATA  out  32  constant 0
- iLDST_REQ  in  1  load response valid
- iLDST_DATA  in  32  load response data

## Operation
- States: IDLE, REQ_FLG, WAIT_FLG, REQ_HDL, WAIT_HDL, DONE.
- IDLE + iRD_START:
  - Latch the IRQ number and base = iSYSREG_IDTR + (IRQ << P_ENTRY_SHIFT). The sum wraps modulo 2^32.
  - Cache index = IRQ[P_CACHE_IDX_W-1:0]; tag = the remaining upper IRQ bits.
  - Hit (entry valid and tag match): load outputs from the cache and go to DONE.
  - Miss: go to REQ_FLG.
- REQ_FLG / REQ_HDL:
  - oLDST_REQ=1, oLDST_ADDR = base+0 or base+4 respectively.
  - The request is taken on the first cycle with iLDST_BUSY=0; then move to the matching WAIT state.
- WAIT_FLG / WAIT_HDL:
  - oLDST_REQ=0; oLDST_ADDR holds the same address.
  - iLDST_REQ captures iLDST_DATA into FLAGS or HUNDLER and advances (WAIT_FLG→REQ_HDL, WAIT_HDL→DONE). The timeout counter is cleared on entry to each WAIT state.
  - If the counter reaches P_TIMEOUT with no response: set error, FLAGS=HUNDLER=0, go to DONE.
  - iLDST_REQ in any state other than WAIT_* is ignored.
- DONE: oRD_FINISH=1 for one cycle, then return to IDLE.
  - Cache fill at the DONE transition only when: the fetch was a miss, no error, flags bit 0=1, and no invalidate occurred since the start. The fill writes valid, tag, flags and handler at the index.
- oLDST_USE=1 in REQ_*/WAIT_* states only.
- oRD_VALID, oRD_ERROR, oRD_FLAGS and oRD_HUNDLER are registered. They hold their values from DONE until the next accepted start, and clear on that start.
- iIDTR_WRITE clears all cache valid bits the same cycle. If it arrives during a miss in flight, that fetch completes normally but its fill is suppressed.
- iIDTR_WRITE together with iRD_START in IDLE: invalidation wins, so the lookup is a miss.

## Timing
- Reset (iRESET_SYNC=1 at a clock edge):
  - State returns to IDLE, all cache valid bits clear, timeout counter clears.
  - All outputs go to 0, except the constants oLDST_ORDER=2'h2, oLDST_RW=0, oLDST_DATA=0.
  - Mid-fetch reset aborts with no oRD_FINISH; a late iLDST_REQ after reset is ignored.
- Hit latency: start accepted at edge 0, oRD_FINISH high in cycle 1.
- Miss latency with zero busy and immediate responses: REQ_FLG at cycle 1, WAIT_FLG at 2, REQ_HDL at 3, WAIT_HDL at 4, DONE at 5. oRD_FINISH is high in cycle 5.
- Each busy cycle adds one cycle; each response-wait cycle adds one cycle.
- Timeout: oRD_FINISH with oRD_ERROR=1 occurs P_TIMEOUT+1 cycles after entering the WAIT state.
- iRD_START while oRD_BUSY=1 is dropped; the requester must re-assert it after oRD_FINISH.

## Test plan
- Miss fetch: IDTR=0x1000, IRQ=5, responses flags=0x1, handler=0x8000_0040 → addresses 0x1028 then 0x102C, FINISH in cycle 5, VALID=1, ERROR=0.
- Hit replay: repeat IRQ=5 → no oLDST_USE, FINISH in cycle 1, handler=0x8000_0040. Then IRQ=9 (same index 1, different tag) → miss, memory read at 0x1048.
- Invalid entry not cached: IRQ=3 with flags=0x0 → VALID=0; repeat IRQ=3 → memory is read again.
- Busy/timeout: iLDST_BUSY held 4 cycles → REQ held 5 cycles with a stable address. Then no response → FINISH at P_TIMEOUT+1 cycles into WAIT_FLG, ERROR=1, FLAGS=HUNDLER=0, no cache fill.
- Invalidation: fill IRQ=5, pulse iIDTR_WRITE, set IDTR=0x2000 → IRQ=5 misses and reads 0x2028. iIDTR_WRITE during WAIT_HDL of a miss → fill suppressed.
- Reset mid-fetch: iRESET_SYNC in WAIT_FLG → outputs zero next cycle, no FINISH, stray iLDST_REQ ignored, next start is a miss.
